key_entry_ctrl: RTL and testbench

//  Sequences PS/2 key events into calculator operands. Sits between the PS/2

---
 rtl/key_entry_if.sv | 24 ++
 rtl/key_entry_ctrl.sv | 126 ++++++++++++
 tb/tb_key_entry_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_entry_if.sv
// Operand handshake bundle between key entry and the calculator ALU.
// The master drives data, valid and index; the slave answers with ready.
interface key_entry_if #(
    parameter int VAL_W = 14
);
    logic [VAL_W-1:0] opnd_data;
    logic             opnd_valid;
    logic             opnd_ready;
    logic             opnd_idx;

    modport master (
        output opnd_data,
        output opnd_valid,
        output opnd_idx,
        input  opnd_ready
    );

    modport slave (
        input  opnd_data,
        input  opnd_valid,
        input  opnd_idx,
        output opnd_ready
    );
endinterface

// File: rtl/key_entry_ctrl.sv
// Turns decoded PS/2 key events into binary calculator operands (A, B, A, ...).
// Digits build the operand; ENTER hands it downstream on valid/ready.
module key_entry_ctrl #(
    parameter int MAX_DIGITS = 4,
    parameter int VAL_W      = 14,
    parameter int KEY_DLY    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_strobe,
    input  logic [7:0]              key_ascii,
    key_entry_if.master             opnd,
    output logic [2:0]              digit_cnt,
    output logic [4*MAX_DIGITS-1:0] disp_bcd,
    output logic                    overflow_err
);
    localparam int         BCD_W   = 4 * MAX_DIGITS;
    localparam logic [2:0] CNT_MAX = 3'(MAX_DIGITS);

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    state_t             r_state;
    logic [VAL_W-1:0]   r_acc;
    logic [VAL_W-1:0]   r_data;
    logic               r_valid;
    logic               r_idx;
    logic [2:0]         r_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;

    logic [KEY_DLY:0]   w_tap;
    logic               w_key_evt;
    logic               w_is_digit;
    logic               w_is_enter;
    logic [3:0]         w_digit;
    logic               w_room;
    logic [VAL_W-1:0]   w_acc_next;
    logic [BCD_W-1:0]   w_bcd_next;
    logic               w_accept;

    // Strobe is delayed to line up with the decoder's late ASCII output.
    assign w_tap[0] = key_strobe;

    genvar g;
    generate
        for (g = 0; g < KEY_DLY; g++) begin : g_dly
            logic r_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= 1'b0;
                end else begin
                    r_q <= w_tap[g];
                end
            end
            assign w_tap[g+1] = r_q;
        end
    endgenerate

    assign w_key_evt  = w_tap[KEY_DLY];
    assign w_is_digit = (key_ascii >= 8'h30) && (key_ascii <= 8'h39);
    assign w_is_enter = (key_ascii == 8'h0A);
    assign w_digit    = key_ascii[3:0];
    assign w_room     = (r_cnt < CNT_MAX);

    // acc*10 as shift-and-add; width rule guarantees no wrap.
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + VAL_W'(w_digit);
    assign w_bcd_next = (r_bcd << 4) | BCD_W'(w_digit);
    assign w_accept   = r_valid && opnd.opnd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ENTRY;
            r_acc   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_idx   <= 1'b0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            case (r_state)
                ST_ENTRY: begin
                    if (w_key_evt && w_is_digit) begin
                        if (w_room) begin
                            r_acc <= w_acc_next;
                            r_bcd <= w_bcd_next;
                            r_cnt <= r_cnt + 3'd1;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end else if (w_key_evt && w_is_enter &&
                                 (r_cnt != 3'd0)) begin
                        r_data  <= r_acc;
                        r_valid <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Keys arriving here are dropped on purpose.
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_acc   <= '0;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_idx   <= ~r_idx;
                        r_state <= ST_ENTRY;
                    end
                end
                default: begin
                    r_state <= ST_ENTRY;
                end
            endcase
        end
    end

    assign opnd.opnd_data  = r_data;
    assign opnd.opnd_valid = r_valid;
    assign opnd.opnd_idx   = r_idx;
    assign digit_cnt       = r_cnt;
    assign disp_bcd        = r_bcd;
    assign overflow_err    = r_ovf;
endmodule

// File: tb/tb_key_entry_ctrl.sv
// Scoreboard bench for key_entry_ctrl: directed key sequences push expected
// operands; a negedge monitor pops them on each accepted handshake.
module tb_key_entry_ctrl;
    logic        clk;
    logic        rst;
    logic        key_strobe;
    logic [7:0]  key_ascii;
    logic [2:0]  digit_cnt;
    logic [15:0] disp_bcd;
    logic        overflow_err;

    int errors = 0;
    int checks = 0;

    int exp_data_q[$];
    bit exp_idx_q[$];

    int rises = 0;
    int vlen_cur = 0;
    int last_vlen = 0;
    int ovf_pulses = 0;
    int ovf_hi = 0;
    bit prev_v = 0;
    bit prev_o = 0;

    key_entry_if #(.VAL_W(14)) ifc ();

    key_entry_ctrl #(
        .MAX_DIGITS(4),
        .VAL_W(14),
        .KEY_DLY(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_strobe(key_strobe),
        .key_ascii(key_ascii),
        .opnd(ifc.master),
        .digit_cnt(digit_cnt),
        .disp_bcd(disp_bcd),
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.opnd_valid && !prev_v) rises++;
            if (ifc.opnd_valid) begin
                vlen_cur++;
            end else if (vlen_cur > 0) begin
                last_vlen = vlen_cur;
                vlen_cur = 0;
            end
            if (overflow_err) ovf_hi++;
            if (overflow_err && !prev_o) ovf_pulses++;
            if (ifc.opnd_valid && ifc.opnd_ready) begin
                if (exp_data_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL sb_unexpected: got data %0d, none expected",
                             ifc.opnd_data);
                end else begin
                    chk("sb_data", int'(ifc.opnd_data), exp_data_q.pop_front());
                    chk("sb_idx", int'(ifc.opnd_idx), int'(exp_idx_q.pop_front()));
                end
            end
        end
        prev_v = ifc.opnd_valid;
        prev_o = overflow_err;
    end

    // Decoder model: ASCII becomes valid one cycle after the strobe.
    task automatic press(input logic [7:0] a);
        @(posedge clk); #1;
        key_strobe = 1'b1;
        key_ascii  = 8'hFF;
        @(posedge clk); #1;
        key_strobe = 1'b0;
        key_ascii  = a;
        @(posedge clk); #1;
        key_ascii  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic expect_op(input int d, input bit i);
        exp_data_q.push_back(d);
        exp_idx_q.push_back(i);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_data_q.size() != 0 || ifc.opnd_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: pending %0d, need 0",
                     name, exp_data_q.size());
        end
        @(negedge clk); #1;
    endtask

    int base_r;
    int base_o;

    initial begin
        rst = 1'b1;
        key_strobe = 1'b0;
        key_ascii = 8'h00;
        ifc.opnd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(ifc.opnd_valid), 0);
        chk("rst_data", int'(ifc.opnd_data), 0);
        chk("rst_idx", int'(ifc.opnd_idx), 0);
        chk("rst_cnt", int'(digit_cnt), 0);
        chk("rst_bcd", int'(disp_bcd), 0);
        chk("rst_ovf", int'(overflow_err), 0);
        rst = 1'b0;

        // 1: 123 with ready already high
        press(8'h31); press(8'h32); press(8'h33);
        chk("t1_cnt", int'(digit_cnt), 3);
        chk("t1_bcd", int'(disp_bcd), 'h0123);
        expect_op(123, 1'b0);
        press(8'h0A);
        wait_idle("t1");
        chk("t1_vlen", last_vlen, 1);
        chk("t1_idx", int'(ifc.opnd_idx), 1);
        chk("t1_cnt_clr", int'(digit_cnt), 0);

        // 2: full buffer then an overflow digit
        press(8'h39); press(8'h39); press(8'h39); press(8'h39);
        chk("t2_cnt", int'(digit_cnt), 4);
        base_o = ovf_pulses;
        base_r = ovf_hi;
        press(8'h35);
        chk("t2_ovf_pulses", ovf_pulses, base_o + 1);
        chk("t2_ovf_len", ovf_hi, base_r + 1);
        chk("t2_bcd", int'(disp_bcd), 'h9999);
        chk("t2_cnt_hold", int'(digit_cnt), 4);
        expect_op(9999, 1'b1);
        press(8'h0A);
        wait_idle("t2");
        chk("t2_idx_wrap", int'(ifc.opnd_idx), 0);

        // 3: empty enter and junk code are ignored
        base_r = rises;
        base_o = ovf_pulses;
        press(8'h0A);
        press(8'hFE);
        chk("t3_rises", rises, base_r);
        chk("t3_valid", int'(ifc.opnd_valid), 0);
        chk("t3_cnt", int'(digit_cnt), 0);
        chk("t3_bcd", int'(disp_bcd), 0);
        chk("t3_idx", int'(ifc.opnd_idx), 0);
        chk("t3_ovf", ovf_pulses, base_o);

        // 4: backpressure, key in SEND dropped
        ifc.opnd_ready = 1'b0;
        base_o = ovf_pulses;
        press(8'h34);
        expect_op(4, 1'b0);
        press(8'h0A);
        press(8'h37);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", int'(ifc.opnd_valid), 1);
            chk("t4_hold_data", int'(ifc.opnd_data), 4);
        end
        chk("t4_cnt_send", int'(digit_cnt), 1);
        chk("t4_bcd_send", int'(disp_bcd), 'h0004);
        @(posedge clk); #1;
        ifc.opnd_ready = 1'b1;
        wait_idle("t4");
        chk("t4_cnt", int'(digit_cnt), 0);
        chk("t4_bcd", int'(disp_bcd), 0);
        chk("t4_idx", int'(ifc.opnd_idx), 1);
        chk("t4_ovf", ovf_pulses, base_o);

        // 5: delayed-ASCII digits, back-to-back operands
        press(8'h35); press(8'h30);
        chk("t5_bcd", int'(disp_bcd), 'h0050);
        expect_op(50, 1'b1);
        press(8'h0A);
        wait_idle("t5a");
        chk("t5_idx_a", int'(ifc.opnd_idx), 0);
        press(8'h31);
        expect_op(1, 1'b0);
        press(8'h0A);
        wait_idle("t5b");
        chk("t5_idx_b", int'(ifc.opnd_idx), 1);

        // 6: asynchronous reset mid-entry
        press(8'h38); press(8'h36);
        chk("t6_cnt", int'(digit_cnt), 2);
        chk("t6_bcd", int'(disp_bcd), 'h0086);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_cnt", int'(digit_cnt), 0);
        chk("t6_rst_bcd", int'(disp_bcd), 0);
        chk("t6_rst_idx", int'(ifc.opnd_idx), 0);
        chk("t6_rst_data", int'(ifc.opnd_data), 0);
        chk("t6_rst_valid", int'(ifc.opnd_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        press(8'h33);
        expect_op(3, 1'b0);
        press(8'h0A);
        wait_idle("t6");
        chk("t6_idx", int'(ifc.opnd_idx), 1);

        chk("sb_drained", exp_data_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1);
    end
endmodule
